// File: rtl/dht11_responder.sv
// dht11_responder: sensor-side DHT11 single-wire responder.
// Detects a host start pulse on the open-drain line and answers with the
// 40-bit frame {hum_int, hum_frac, temp_int, temp_frac, checksum}, MSB first.
module dht11_responder #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int START_MIN_US  = 10000,
    parameter int RESP_DELAY_US = 30
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    inout  wire        dht_data,
    input  logic [7:0] i_Hum_Int,
    input  logic [7:0] i_Hum_Float,
    input  logic [7:0] i_Temp_Int,
    input  logic [7:0] i_Temp_Float,
    input  logic       i_Err_Inject,
    input  logic       i_Mute,
    output logic       o_busy,
    output logic       o_start_seen,
    output logic       o_frame_done
);

    localparam int DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // Phase counter is wide enough to hold START_MIN_US; it saturates.
    localparam int PH_W = 16;
    localparam logic [PH_W-1:0] PH_START_MIN = PH_W'(START_MIN_US);
    localparam logic [PH_W-1:0] PH_RESP_LAST = PH_W'(RESP_DELAY_US - 1);
    localparam logic [PH_W-1:0] PH_ACK_LAST  = PH_W'(79);
    localparam logic [PH_W-1:0] PH_LOW_LAST  = PH_W'(49);
    localparam logic [PH_W-1:0] PH_ZERO_LAST = PH_W'(26);
    localparam logic [PH_W-1:0] PH_ONE_LAST  = PH_W'(69);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_HOST_LOW   = 3'd1;
    localparam logic [2:0] S_RESP_DELAY = 3'd2;
    localparam logic [2:0] S_ACK_LOW    = 3'd3;
    localparam logic [2:0] S_ACK_HIGH   = 3'd4;
    localparam logic [2:0] S_BIT_LOW    = 3'd5;
    localparam logic [2:0] S_BIT_HIGH   = 3'd6;
    localparam logic [2:0] S_END_LOW    = 3'd7;

    logic [2:0]       r_state;
    logic [1:0]       r_sync;
    logic             r_line_d;
    logic [DIV_W-1:0] r_div;
    logic [PH_W-1:0]  r_phase;
    logic [5:0]       r_bit_cnt;
    logic [39:0]      r_shift;
    logic             r_busy;
    logic             r_start_seen;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_fall;
    logic             w_rise;
    logic             w_drive_low;
    logic [PH_W-1:0]  w_ph_last;
    logic             w_ph_done;
    logic [9:0]       w_sum;
    logic [7:0]       w_crc;
    logic [5:0]       w_bit_cnt_next;

    assign w_tick = (r_div == DIV_LAST);
    assign w_fall = r_line_d & ~r_sync[1];
    assign w_rise = ~r_line_d & r_sync[1];

    assign w_sum = {2'b00, i_Hum_Int} + {2'b00, i_Hum_Float}
                 + {2'b00, i_Temp_Int} + {2'b00, i_Temp_Float};
    assign w_crc = w_sum[7:0] ^ {7'b0000000, i_Err_Inject};

    assign w_bit_cnt_next = r_bit_cnt + 6'd1;
    assign w_ph_done      = w_tick && (r_phase == w_ph_last);

    assign w_drive_low = (r_state == S_ACK_LOW) || (r_state == S_BIT_LOW) ||
                         (r_state == S_END_LOW);
    assign dht_data    = w_drive_low ? 1'b0 : 1'bz;

    assign o_busy       = r_busy;
    assign o_start_seen = r_start_seen;
    assign o_frame_done = r_frame_done;

    // Last tick index of the current phase (phase of N us ends on tick N).
    always_comb begin
        w_ph_last = '1;
        case (r_state)
            S_RESP_DELAY: w_ph_last = PH_RESP_LAST;
            S_ACK_LOW:    w_ph_last = PH_ACK_LAST;
            S_ACK_HIGH:   w_ph_last = PH_ACK_LAST;
            S_BIT_LOW:    w_ph_last = PH_LOW_LAST;
            S_BIT_HIGH:   w_ph_last = r_shift[39] ? PH_ONE_LAST : PH_ZERO_LAST;
            S_END_LOW:    w_ph_last = PH_LOW_LAST;
            default:      w_ph_last = '1;
        endcase
    end

    // Two-flop line synchronizer plus delayed copy for edge detection.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sync   <= 2'b11;
            r_line_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], dht_data};
            r_line_d <= r_sync[1];
        end
    end

    // Free-running microsecond divider.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Protocol FSM; phase counter is cleared on every state change.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_busy       <= 1'b0;
            r_start_seen <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_start_seen <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_tick && (r_phase != '1)) begin
                r_phase <= r_phase + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_HOST_LOW;
                        r_phase <= '0;
                    end
                end
                S_HOST_LOW: begin
                    if (w_rise) begin
                        r_state <= S_IDLE;
                        r_phase <= '0;
                        if (r_phase >= PH_START_MIN) begin
                            r_start_seen <= 1'b1;
                            if (!i_Mute) begin
                                r_shift   <= {i_Hum_Int, i_Hum_Float, i_Temp_Int,
                                              i_Temp_Float, w_crc};
                                r_bit_cnt <= '0;
                                r_busy    <= 1'b1;
                                r_state   <= S_RESP_DELAY;
                            end
                        end
                    end
                end
                S_RESP_DELAY: begin
                    if (w_ph_done) begin
                        r_state <= S_ACK_LOW;
                        r_phase <= '0;
                    end
                end
                S_ACK_LOW: begin
                    if (w_ph_done) begin
                        r_state <= S_ACK_HIGH;
                        r_phase <= '0;
                    end
                end
                S_ACK_HIGH: begin
                    if (w_ph_done) begin
                        r_state <= S_BIT_LOW;
                        r_phase <= '0;
                    end
                end
                S_BIT_LOW: begin
                    if (w_ph_done) begin
                        r_state <= S_BIT_HIGH;
                        r_phase <= '0;
                    end
                end
                S_BIT_HIGH: begin
                    if (w_ph_done) begin
                        r_shift   <= {r_shift[38:0], 1'b0};
                        r_bit_cnt <= w_bit_cnt_next;
                        r_phase   <= '0;
                        r_state   <= (w_bit_cnt_next == 6'd40) ? S_END_LOW : S_BIT_LOW;
                    end
                end
                S_END_LOW: begin
                    if (w_ph_done) begin
                        r_state      <= S_IDLE;
                        r_phase      <= '0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Sensor-side model of the DHT11 single-wire protocol. It watches the shared open-drain data line for a host start pulse and answers with the standard 40-bit frame: humidity integer, humidity fraction, temperature integer, temperature fraction, checksum. It is the responder for the existing DHT11 host interface and plugs in where the physical sensor would sit, for on-board loopback and regression benches.

## Interface
- CLK_FREQ_HZ, 50_000_000: system clock frequency. Must be a multiple of 1_000_000.
- START_MIN_US, 10000: minimum host low time, in µs, accepted as a start request.
- RESP_DELAY_US, 30: released time from host release to the sensor ack.
- i_Clock  input  1  system clock, single clock domain.
- i_Rst_n  input  1  asynchronous, active-low reset.
- dht_data  inout  1  open-drain data line. The block drives only 0 or Z; the pull-up is external.
- i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float  input  8 each  payload bytes.
- i_Err_Inject  input  1  when 1 at latch time, bit 0 of the sent checksum is inverted.
- i_Mute  input  1  when 1 at start detection, the block does not answer.
- o_busy  output  1  high from start acceptance to frame end.
- o_start_seen  output  1  one-cycle pulse when a valid start is detected.
- o_frame_done  output  1  one-cycle pulse when the frame completes.

## Operation
- **Line sampling:** dht_data is sampled through a 2-flop synchronizer. All edge decisions use the synchronized value.
- **Microsecond tick:**
  - A divider produces a one-cycle tick every CLK_FREQ_HZ/1e6 cycles.
  - A phase counter clears on every state entry and counts ticks.
  - A phase of N µs ends on its N-th tick.
- **FSM states and transitions:**
  - **IDLE:** line released. On a synchronized falling edge -> HOST_LOW.
  - **HOST_LOW:** count low µs, saturating. On a rising edge:
    - count < START_MIN_US -> IDLE, with no pulse.
    - count ≥ START_MIN_US -> pulse o_start_seen.
      - If i_Mute = 1 -> IDLE.
      - Otherwise latch the payload into a 40-bit shift register and go to RESP_DELAY.
  - **RESP_DELAY:** release for RESP_DELAY_US -> ACK_LOW.
  - **ACK_LOW:** drive low 80 µs -> ACK_HIGH.
  - **ACK_HIGH:** release 80 µs -> BIT_LOW.
  - **BIT_LOW:** drive low 50 µs -> BIT_HIGH.
  - **BIT_HIGH:** release for 27 µs if the current bit is 0, or 70 µs if it is 1. Then shift and increment the bit counter.
    - Counter < 40 -> BIT_LOW.
    - Counter = 40 -> END_LOW.
  - **END_LOW:** drive low 50 µs, then release, pulse o_frame_done -> IDLE.
- **Frame content:** bytes are sent in the order Hum_Int, Hum_Float, Temp_Int, Temp_Float, CRC, MSB first.
  - CRC = (sum of the four bytes) mod 256, i.e. a 10-bit sum truncated to 8 bits.
  - If i_Err_Inject = 1, CRC is XORed with 0x01.
  - Payload, mute and error-inject are sampled only at start acceptance. Changes mid-frame have no effect on the current frame.
- **Line activity during a response:** host activity on the line is ignored from RESP_DELAY through END_LOW. The line is monitored again only in IDLE.
- **Bit counter:** 6 bits. It does not wrap, because it exits at 40.

## Timing
- **Reset values:**
  - dht_data = Z; o_busy = 0; o_start_seen = 0; o_frame_done = 0.
  - State IDLE; divider, phase counter, bit counter and shift register all 0.
  - Reset is asynchronous: the line is released within the same cycle i_Rst_n falls.
- **Start latency:** o_start_seen asserts 2–3 clocks after the host releases the line (synchronizer plus edge detect).
- **Phase tolerance:** the divider free-runs, so every phase is N µs +0/−1 tick granularity. Total tolerance is under 1 µs per phase.
- **Frame duration:** nominally RESP_DELAY + 160 + 40×50 + Σ(bit high) + 50 µs.
- **o_busy:** rises in the cycle o_start_seen pulses. It falls in the cycle o_frame_done pulses.
- **Muted start:** o_start_seen pulses, o_busy stays 0.
- **Long host low:** the HOST_LOW counter saturates, with no wrap. Any length ≥ START_MIN_US is accepted.

## Test plan
All tests use CLK_FREQ_HZ = 50e6, START_MIN_US = 100, with a pull-up on dht_data.

1. **Nominal frame:** payload 0x37, 0x00, 0x19, 0x00. Host drives low 200 µs, then releases.
   - Required response: 30 µs released, 80 µs low, 80 µs high.
   - Decoded bytes: 0x37 00 19 00 50; o_frame_done pulses once; line ends Z.
2. **Short pulse:** host low 50 µs, then releases.
   - Required response: no o_start_seen, line stays Z, o_busy stays 0.
3. **Checksum wrap and error injection:** payload 0xFF, 0xFF, 0x01, 0x02.
   - Required CRC: 0x01.
   - Repeat with i_Err_Inject = 1: CRC 0x00.
4. **Mute:** i_Mute = 1, valid 200 µs start.
   - Required response: o_start_seen pulses, no drive on the line, o_busy = 0.
   - Next start with i_Mute = 0 is answered normally.
5. **Reset mid-frame:** assert i_Rst_n low during bit 12.
   - Required response: line Z in the same cycle, all outputs 0.
   - After release, a new start returns a correct frame.
6. **Latch stability:** change i_Temp_Int from 0x19 to 0x42 during bit 5.
   - Required response: the frame still carries 0x19 and CRC 0x50.
